ap_txn_profiler: RTL

Hardware transaction profiler for one HLS kernel using the `ap_ctrl_hs`/`ap_ctrl_chain` handshake (`ap_start`, `ap_ready`, `ap_done`, `ap_continue`). It sits directly upstream of the dataflow status dumper. It converts raw handshake activity into per-transaction records (ID, latency, start interval, output stall) and buffers them in a FIFO with a valid/ready read port for the dumper to consume. It also flags protocol errors and record loss.

---
 rtl/ap_txn_profiler.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ap_txn_profiler.sv
// ap_txn_profiler: turns ap_ctrl_hs/ap_ctrl_chain handshake activity of one
// HLS kernel into per-transaction records {id, latency, interval, stall}.
// Records are buffered in a show-ahead FIFO with a valid/ready read port.
// Optional build macro: AP_TXN_PROFILER_STALL_EN enables the output-stall
// accumulator; without it rec_stall is constant 0.
module ap_txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int TS_DEPTH   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ap_start,
  input  logic                        ap_ready,
  input  logic                        ap_done,
  input  logic                        ap_continue,
  input  logic                        finish,
  output logic                        rec_valid,
  input  logic                        rec_ready,
  output logic [ID_W-1:0]             rec_id,
  output logic [CNT_W-1:0]            rec_latency,
  output logic [CNT_W-1:0]            rec_interval,
  output logic [CNT_W-1:0]            rec_stall,
  output logic [$clog2(TS_DEPTH):0]   outstanding,
  output logic [15:0]                 drop_count,
  output logic                        overflow,
  output logic                        protocol_err,
  output logic                        drained
);

  localparam int TS_AW = $clog2(TS_DEPTH);
  localparam int FF_AW = $clog2(FIFO_DEPTH);
  localparam logic [TS_AW:0] LP_TS_FULL = (TS_AW+1)'(TS_DEPTH);
  localparam logic [FF_AW:0] LP_FF_FULL = (FF_AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_PEND} s_state_t;
  typedef enum logic [1:0] {D_RUN, D_DRAIN, D_DONE} d_state_t;

  s_state_t         r_sstate;
  d_state_t         r_dstate;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_prev_begin;
  logic             r_have_prev;
  logic [ID_W-1:0]  r_id;

  // Outstanding-start queue: begin timestamp plus the interval of that txn
  logic [CNT_W-1:0] r_ts_mem [TS_DEPTH];
  logic [CNT_W-1:0] r_iv_mem [TS_DEPTH];
  logic [TS_AW-1:0] r_ts_wr;
  logic [TS_AW-1:0] r_ts_rd;
  logic [TS_AW:0]   r_ts_cnt;

  // Record FIFO
  logic [ID_W-1:0]  r_f_id  [FIFO_DEPTH];
  logic [CNT_W-1:0] r_f_lat [FIFO_DEPTH];
  logic [CNT_W-1:0] r_f_iv  [FIFO_DEPTH];
  logic [FF_AW-1:0] r_f_wr;
  logic [FF_AW-1:0] r_f_rd;
  logic [FF_AW:0]   r_f_cnt;

  logic [15:0]      r_drop;
  logic             r_ovf;
  logic             r_perr;
  logic             r_drained;

  logic             w_done_hs;
  logic             w_begin;
  logic             w_ts_empty;
  logic             w_ts_full;
  logic             w_ts_pop;
  logic             w_bypass;
  logic             w_begin_acc;
  logic             w_ts_push;
  logic             w_ts_ovf;
  logic             w_perr;
  logic [CNT_W-1:0] w_interval;
  logic             w_rec_form;
  logic [CNT_W-1:0] w_rec_lat;
  logic [CNT_W-1:0] w_rec_iv;
  logic             w_f_pop;
  logic             w_f_space;
  logic             w_f_push;
  logic             w_drop;
  logic [TS_AW:0]   w_ts_cnt_nxt;
  logic [FF_AW:0]   w_f_cnt_nxt;

  // A begin is only recognised from S_IDLE and only while not draining.
  // A full timestamp queue still accepts a begin when a done pops the same cycle.
  // With an empty queue, a same-cycle begin and done bypass the queue entirely.
  assign w_done_hs    = ap_done & ap_continue;
  assign w_begin      = (r_sstate == S_IDLE) & ap_start & (r_dstate == D_RUN);
  assign w_ts_empty   = (r_ts_cnt == '0);
  assign w_ts_full    = (r_ts_cnt == LP_TS_FULL);
  assign w_ts_pop     = w_done_hs & ~w_ts_empty;
  assign w_bypass     = w_done_hs & w_ts_empty & w_begin;
  assign w_begin_acc  = w_begin & (~w_ts_full | w_ts_pop);
  assign w_ts_push    = w_begin_acc & ~w_bypass;
  assign w_ts_ovf     = w_begin & ~w_begin_acc;
  assign w_perr       = w_done_hs & w_ts_empty & ~w_begin;
  assign w_interval   = r_have_prev ? (r_cyc - r_prev_begin) : '0;
  assign w_rec_form   = w_ts_pop | w_bypass;
  assign w_rec_lat    = w_bypass ? CNT_W'(1) : (r_cyc - r_ts_mem[r_ts_rd] + CNT_W'(1));
  assign w_rec_iv     = w_bypass ? w_interval : r_iv_mem[r_ts_rd];

  // A pop frees space before the push, so a full FIFO being read never drops.
  assign w_f_pop      = (r_f_cnt != '0) & rec_ready;
  assign w_f_space    = (r_f_cnt != LP_FF_FULL) | w_f_pop;
  assign w_f_push     = w_rec_form & w_f_space;
  assign w_drop       = w_rec_form & ~w_f_space;

  assign w_ts_cnt_nxt = r_ts_cnt + {{TS_AW{1'b0}}, w_ts_push} - {{TS_AW{1'b0}}, w_ts_pop};
  assign w_f_cnt_nxt  = r_f_cnt + {{FF_AW{1'b0}}, w_f_push} - {{FF_AW{1'b0}}, w_f_pop};

  // Free-running cycle counter, wraps modulo 2^CNT_W
  always_ff @(posedge clock) begin
    if (reset) r_cyc <= '0;
    else       r_cyc <= r_cyc + CNT_W'(1);
  end

  // Start-side FSM tracking the ap_start/ap_ready handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sstate <= S_IDLE;
    end else begin
      case (r_sstate)
        S_IDLE:  if (w_begin && !ap_ready) r_sstate <= S_PEND;
        S_PEND:  if (ap_ready) r_sstate <= S_IDLE;
        default: r_sstate <= S_IDLE;
      endcase
    end
  end

  // Timestamp queue control, previous-begin tracking and transaction id
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ts_wr     <= '0;
      r_ts_rd     <= '0;
      r_ts_cnt    <= '0;
      r_have_prev <= 1'b0;
      r_id        <= '0;
    end else begin
      if (w_ts_push)   r_ts_wr     <= r_ts_wr + TS_AW'(1);
      if (w_ts_pop)    r_ts_rd     <= r_ts_rd + TS_AW'(1);
      r_ts_cnt <= w_ts_cnt_nxt;
      if (w_begin_acc) r_have_prev <= 1'b1;
      if (w_rec_form)  r_id        <= r_id + ID_W'(1);
    end
  end

  // Timestamp queue storage and previous-begin value (qualified by control)
  always_ff @(posedge clock) begin
    if (w_ts_push) begin
      r_ts_mem[r_ts_wr] <= r_cyc;
      r_iv_mem[r_ts_wr] <= w_interval;
    end
    if (w_begin_acc) r_prev_begin <= r_cyc;
  end

  // Record FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_f_wr  <= '0;
      r_f_rd  <= '0;
      r_f_cnt <= '0;
    end else begin
      if (w_f_push) r_f_wr <= r_f_wr + FF_AW'(1);
      if (w_f_pop)  r_f_rd <= r_f_rd + FF_AW'(1);
      r_f_cnt <= w_f_cnt_nxt;
    end
  end

  // Record FIFO storage
  always_ff @(posedge clock) begin
    if (w_f_push) begin
      r_f_id[r_f_wr]  <= r_id;
      r_f_lat[r_f_wr] <= w_rec_lat;
      r_f_iv[r_f_wr]  <= w_rec_iv;
    end
  end

`ifdef AP_TXN_PROFILER_STALL_EN
  logic [CNT_W-1:0] r_stall_acc;
  logic [CNT_W-1:0] r_f_stl [FIFO_DEPTH];

  // Count cycles where the kernel holds done but downstream refuses it
  always_ff @(posedge clock) begin
    if (reset)          r_stall_acc <= '0;
    else if (w_done_hs) r_stall_acc <= '0;
    else if (ap_done)   r_stall_acc <= r_stall_acc + CNT_W'(1);
  end

  // Stall field of the record FIFO
  always_ff @(posedge clock) begin
    if (w_f_push) r_f_stl[r_f_wr] <= r_stall_acc;
  end

  assign rec_stall = rec_valid ? r_f_stl[r_f_rd] : '0;
`else
  assign rec_stall = '0;
`endif

  // Sticky error flags and saturating drop counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (w_drop || w_ts_ovf)           r_ovf  <= 1'b1;
      if (w_perr)                       r_perr <= 1'b1;
    end
  end

  // Drain FSM: done once nothing is queued or outstanding after this edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dstate  <= D_RUN;
      r_drained <= 1'b0;
    end else begin
      case (r_dstate)
        D_RUN:   if (finish) r_dstate <= D_DRAIN;
        D_DRAIN: if (w_f_cnt_nxt == '0 && w_ts_cnt_nxt == '0) begin
                   r_dstate  <= D_DONE;
                   r_drained <= 1'b1;
                 end
        D_DONE:  r_drained <= 1'b1;
        default: r_dstate  <= D_RUN;
      endcase
    end
  end

  // Show-ahead read port; data reads as zero while the FIFO is empty
  assign rec_valid    = (r_f_cnt != '0);
  assign rec_id       = rec_valid ? r_f_id[r_f_rd]  : '0;
  assign rec_latency  = rec_valid ? r_f_lat[r_f_rd] : '0;
  assign rec_interval = rec_valid ? r_f_iv[r_f_rd]  : '0;
  assign outstanding  = r_ts_cnt;
  assign drop_count   = r_drop;
  assign overflow     = r_ovf;
  assign protocol_err = r_perr;
  assign drained      = r_drained;

endmodule
